sortpipe_sched: RTL and testbench
=================================

Name: sortpipe_sched

Overview:
- Issue scheduler for the radix-sort input stage (LDQ -> bitonic sort network -> input-bin counter calculation).
- Pops LDQ lines into the fixed-latency sort pipeline only while downstream input bins have reserved space, using credits.
- Counts the lines of one batch, then drains the pipeline and signals batch completion.
- Sits between the load queue and the sort datapath, one instance per sort datapath.

Parameters:
- PIPE_DEPTH, 6: latency of the sort pipeline in enabled cycles (NUM_BIOTONIC_STGS_TOT).
- CREDITS, 16: downstream line slots available after reset.
- BITS_CREDIT, 5: width of the credit counter; must hold CREDITS.
- BITS_LINES, 16: width of the batch line counter.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- mode, input, 1: block is enabled only when mode == MODE_WORK.
- unit_en, input, 1: unit enable.
- start, input, 1: begin a batch; sampled only in IDLE.
- num_lines, input, BITS_LINES: lines in the batch; sampled with start.
- ldq_empty, input, 1: load queue has no line.
- credit_return, input, 1: downstream freed one line slot.
- ldq_rd, output, 1: pop one LDQ line this cycle.
- ldq_data_valid, output, 1: LDQ data presented to the datapath this cycle.
- pipe_en, output, 1: global enable to the sort network and its delay lines.
- busy, output, 1: state is not IDLE.
- done, output, 1: one-cycle batch-complete pulse.
- credits, output, BITS_CREDIT: current free credits.
- err_credit_ovf, output, 1: sticky credit-overflow flag.

Behaviour:
- en = (mode == MODE_WORK) && unit_en. pipe_en = en, combinational.
- When en = 0, all state, counters and ldq_data_valid freeze; ldq_rd is forced to 0; this is not an abort.
- Reset values (rst = 1 at a clock edge):
  - state = IDLE.
  - ldq_rd = 0, ldq_data_valid = 0, done = 0, busy = 0.
  - credits = CREDITS, lines_left = 0, drain_ctr = 0, err_credit_ovf = 0.
  - Reset mid-batch discards the batch with no done pulse. Data already in the datapath is not the scheduler's concern.
- State machine, all transitions qualified by en:
  - IDLE: start && num_lines != 0 -> STREAM, lines_left = num_lines. start && num_lines == 0 -> DONE.
  - STREAM: issue = !ldq_empty && credits != 0 && lines_left != 0. ldq_rd = issue, combinational. On issue, lines_left decrements. When the issue takes lines_left from 1 to 0 -> DRAIN, drain_ctr = PIPE_DEPTH + 1.
  - DRAIN: drain_ctr decrements each enabled cycle. On the transition from 1 to 0 -> DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Latency:
  - ldq_data_valid is registered: it equals ldq_rd delayed one enabled cycle, matching the 1-cycle LDQ read latency.
  - The last line leaves the sort network PIPE_DEPTH enabled cycles after its ldq_data_valid.
  - done rises in the cycle after that line's output is valid.
  - For a single line issued at enabled cycle t, done = 1 at cycle t + PIPE_DEPTH + 2, with no en gaps.
- Credits:
  - Issue decrements credits; credit_return increments them.
  - Issue and credit_return in the same cycle leave credits unchanged.
  - credit_return when credits == CREDITS and no issue in that cycle: count saturates and err_credit_ovf is set. It clears only on rst.
  - credits never underflows: issue requires credits != 0.
  - credit_return is accepted in every state, including IDLE, and is counted even when en = 0.
- Back-to-back batches: start is accepted in the cycle after DONE, i.e. once IDLE is reached.

Decomposition:
- Shared package sortpipe_pkg holds:
  - the state enum typedef (IDLE, STREAM, DRAIN, DONE);
  - the MODE_WORK constant, re-exported from definitions.vh;
  - the default CREDITS and PIPE_DEPTH constants.
- One natural sub-module: credit_ctr, an up/down saturating counter with an overflow flag (ports inc, dec, count, ovf).

Test Plan:
- Basic batch: rst, then start with num_lines = 4, ldq_empty = 0, credits 16. Required: ldq_rd high for 4 consecutive cycles; ldq_data_valid the same 4 cycles shifted +1; credits = 12; done pulses exactly once, PIPE_DEPTH + 2 cycles after the last ldq_rd.
- Credit exhaustion: CREDITS = 2, num_lines = 5, no credit_return. Required: exactly 2 ldq_rd, then stall in STREAM. Send 3 credit_return pulses one cycle apart. Required: the remaining 3 issues follow, credits = 0, then done.
- Simultaneous issue and return: credit_return held high throughout an 8-line batch. Required: credits stays 16 and err_credit_ovf stays 0.
- Enable gaps: unit_en low for 3 cycles mid-STREAM and 2 cycles mid-DRAIN. Required: ldq_rd = 0 and pipe_en = 0 during the gaps; done is delayed by exactly 5 cycles versus the no-gap run.
- Boundaries: start with num_lines = 0. Required: done is asserted one cycle after start and no ldq_rd occurs. credit_return in IDLE at full credits. Required: err_credit_ovf = 1, credits = 16.
- Reset mid-batch: rst in DRAIN. Required: next cycle state = IDLE, credits = 16, done = 0, err_credit_ovf = 0; a new start then runs normally.

Source files
------------

// File: rtl/sortpipe_pkg.sv
// Shared types and constants for the radix-sort input-stage issue scheduler.
package sortpipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Mirrors the MODE_WORK encoding from definitions.vh
    localparam logic MODE_WORK = 1'b1;

    localparam int DEF_CREDITS    = 16;
    localparam int DEF_PIPE_DEPTH = 6;

endpackage

// File: rtl/credit_ctr.sv
// Up/down credit counter that saturates at its reset value and flags returns beyond it.
module credit_ctr #(
    parameter int WIDTH = 5,
    parameter int MAX   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    logic [WIDTH-1:0] count_reg;
    logic             ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= MAX_C;
            ovf_reg   <= 1'b0;
        end else if (inc && !dec) begin
            // A return with every slot already free means downstream over-returned
            if (count_reg == MAX_C) begin
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/sortpipe_sched.sv
// Issue scheduler: pops LDQ lines into the fixed-latency sort pipeline under
// downstream credit control, then drains the pipeline and pulses done.
module sortpipe_sched
    import sortpipe_pkg::*;
#(
    parameter int PIPE_DEPTH  = DEF_PIPE_DEPTH,
    parameter int CREDITS     = DEF_CREDITS,
    parameter int BITS_CREDIT = 5,
    parameter int BITS_LINES  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   unit_en,
    input  logic                   start,
    input  logic [BITS_LINES-1:0]  num_lines,
    input  logic                   ldq_empty,
    input  logic                   credit_return,
    output logic                   ldq_rd,
    output logic                   ldq_data_valid,
    output logic                   pipe_en,
    output logic                   busy,
    output logic                   done,
    output logic [BITS_CREDIT-1:0] credits,
    output logic                   err_credit_ovf
);

    localparam int BITS_DRAIN = $clog2(PIPE_DEPTH + 2);
    // One extra cycle covers the LDQ read latency ahead of the sort network
    localparam logic [BITS_DRAIN-1:0] DRAIN_LOAD = BITS_DRAIN'(PIPE_DEPTH + 1);

    state_t                  state_reg, state_next;
    logic [BITS_LINES-1:0]   lines_left_reg, lines_left_next;
    logic [BITS_DRAIN-1:0]   drain_ctr_reg, drain_ctr_next;
    logic                    ldq_data_valid_reg;
    logic                    en;
    logic                    issue;

    assign en      = (mode == MODE_WORK) && unit_en;
    assign pipe_en = en;
    assign issue   = en && (state_reg == STREAM) && !ldq_empty
                     && (credits != '0) && (lines_left_reg != '0);

    // Returns are counted regardless of en so no downstream credit is lost
    credit_ctr #(
        .WIDTH (BITS_CREDIT),
        .MAX   (CREDITS)
    ) u_credit_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (credit_return),
        .dec   (issue),
        .count (credits),
        .ovf   (err_credit_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            lines_left_reg     <= '0;
            drain_ctr_reg      <= '0;
            ldq_data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lines_left_reg <= lines_left_next;
            drain_ctr_reg  <= drain_ctr_next;
            if (en) begin
                ldq_data_valid_reg <= issue;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        lines_left_next = lines_left_reg;
        drain_ctr_next  = drain_ctr_reg;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (num_lines != '0) begin
                            state_next      = STREAM;
                            lines_left_next = num_lines;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                STREAM: begin
                    if (issue) begin
                        lines_left_next = lines_left_reg - 1'b1;
                        if (lines_left_reg == BITS_LINES'(1)) begin
                            state_next     = DRAIN;
                            drain_ctr_next = DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    drain_ctr_next = drain_ctr_reg - 1'b1;
                    if (drain_ctr_reg == BITS_DRAIN'(1)) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ldq_rd         = issue;
        ldq_data_valid = ldq_data_valid_reg;
        busy           = (state_reg != IDLE);
        // Qualified by en so a frozen DONE state still yields a single pulse
        done           = en && (state_reg == DONE);
    end

endmodule

// File: tb/tb_sortpipe_sched.sv
// Scoreboard bench for sortpipe_sched: stimulus queues expected batch completions,
// a negedge monitor checks every done pulse plus per-cycle enable/valid relations.
module tb_sortpipe_sched;
    import sortpipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = MODE_WORK;
    logic        unit_en = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_lines = '0;
    logic        ldq_empty = 1'b0;
    logic        credit_return = 1'b0;
    logic        ldq_rd, ldq_data_valid, pipe_en, busy, done, err_credit_ovf;
    logic [4:0]  credits;

    sortpipe_sched #(
        .PIPE_DEPTH  (6),
        .CREDITS     (16),
        .BITS_CREDIT (5),
        .BITS_LINES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode           (mode),
        .unit_en        (unit_en),
        .start          (start),
        .num_lines      (num_lines),
        .ldq_empty      (ldq_empty),
        .credit_return  (credit_return),
        .ldq_rd         (ldq_rd),
        .ldq_data_valid (ldq_data_valid),
        .pipe_en        (pipe_en),
        .busy           (busy),
        .done           (done),
        .credits        (credits),
        .err_credit_ovf (err_credit_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    lines;
        int    credits;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   lines_seen = 0;
    logic valid_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Data-valid reference: the read strobe delayed by one enabled cycle
    always @(posedge clk) begin
        if (rst) valid_exp <= 1'b0;
        else if (mode == MODE_WORK && unit_en) valid_exp <= ldq_rd;
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("pipe_en", int'(pipe_en), int'(mode == MODE_WORK && unit_en));
            if (!(mode == MODE_WORK && unit_en)) chk("ldq_rd_gap", int'(ldq_rd), 0);
            chk("ldq_data_valid", int'(ldq_data_valid), int'(valid_exp));
            if (ldq_rd) lines_seen++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("done %s: cycle %0d lines %0d credits %0d", e.name, cyc, lines_seen, credits);
                    chk({e.name, "_done_cycle"}, cyc, e.cyc);
                    chk({e.name, "_lines"}, lines_seen, e.lines);
                    chk({e.name, "_credits"}, int'(credits), e.credits);
                end
                lines_seen = 0;
            end
        end else begin
            lines_seen = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int n);
        num_lines = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_exp(input string name, input int c, input int l, input int cr);
        exp_t e;
        e.name = name; e.cyc = c; e.lines = l; e.credits = cr;
        sb.push_back(e);
    endtask

    task automatic wait_drained();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("scoreboard_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic give_credits(input int n);
        credit_return = 1'b1;
        repeat (n) tick();
        credit_return = 1'b0;
    endtask

    initial begin
        int s;
        int r;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_credits", int'(credits), 16);
        chk("rst_ovf", int'(err_credit_ovf), 0);
        chk("rst_ldq_rd", int'(ldq_rd), 0);
        chk("rst_valid", int'(ldq_data_valid), 0);
        tick();

        // Basic 4-line batch: issues s+1..s+4, done at last issue + 8
        s = cyc;
        push_exp("basic", s + 12, 4, 12);
        start_batch(4);
        wait_drained();
        give_credits(4);
        chk("basic_refill", int'(credits), 16);

        // Reduce to 2 credits, then a 5-line batch must stall after 2 issues
        s = cyc;
        push_exp("drain14", s + 22, 14, 2);
        start_batch(14);
        wait_drained();
        s = cyc;
        start_batch(5);
        repeat (4) tick();
        r = cyc;
        chk("stall_credits", int'(credits), 0);
        chk("stall_busy", int'(busy), 1);
        push_exp("exhaust", r + 13, 5, 0);
        credit_return = 1'b1; tick(); credit_return = 1'b0; tick();
        credit_return = 1'b1; tick(); credit_return = 1'b0; tick();
        credit_return = 1'b1; tick(); credit_return = 1'b0;
        wait_drained();
        give_credits(16);
        chk("exhaust_refill", int'(credits), 16);

        // Return held high across every issue cycle of an 8-line batch
        s = cyc;
        push_exp("simul", s + 16, 8, 16);
        start_batch(8);
        credit_return = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("simul_credits", int'(credits), 16);
        end
        credit_return = 1'b0;
        wait_drained();
        chk("simul_ovf", int'(err_credit_ovf), 0);

        // Enable gaps: 3 cycles in STREAM, 2 in DRAIN -> 5 cycles later than basic
        s = cyc;
        push_exp("gaps", s + 17, 4, 12);
        start_batch(4);
        unit_en = 1'b0; repeat (3) tick();
        unit_en = 1'b1; repeat (5) tick();
        unit_en = 1'b0; repeat (2) tick();
        unit_en = 1'b1;
        wait_drained();
        give_credits(4);

        // Zero-line batch completes one cycle after start with no reads
        s = cyc;
        push_exp("zero", s + 1, 0, 16);
        start_batch(0);
        wait_drained();

        // Over-return in IDLE at full credits
        give_credits(1);
        chk("ovf_flag", int'(err_credit_ovf), 1);
        chk("ovf_credits", int'(credits), 16);

        // Reset while in DRAIN discards the batch
        s = cyc;
        start_batch(2);
        repeat (4) tick();
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_credits", int'(credits), 16);
        chk("midrst_done", int'(done), 0);
        chk("midrst_ovf", int'(err_credit_ovf), 0);
        s = cyc;
        push_exp("post_rst", s + 11, 3, 13);
        start_batch(3);
        wait_drained();
        repeat (3) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
